wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Write-back stage of the 5-stage MIPS pipeline. Sits directly downstream of the MEM stage and consumes its registered outputs: ALU result, destination register, memory enables, register write enable and load data.
- Performs load-data extraction (byte, half, word; signed or unsigned), waits on a data-memory ready signal for multi-cycle loads, and drives the register-file write port and the WB forwarding bus.

Parameters:
- DATA_W, 32, datapath width
- WAIT_MAX, 15, max cycles to wait for mem_rdy before declaring a bus error
- CNT_W, 32, width of retire counter (used only with the optional feature)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  MEM stage presents an instruction this cycle
- in_ready  out  1  WB can accept; low stalls the MEM stage
- alu_result_in  in  DATA_W  ALU result / memory address
- w_in  in  5  destination register
- data_mem_en_in  in  1  memory access
- data_mem_wen_in  in  1  memory write (store)
- reg_wen_in  in  1  register write request
- load_size_in  in  2  00 word, 01 half, 10 byte, 11 reserved (treated as word)
- load_signed_in  in  1  sign-extend sub-word load
- mem_read_data  in  DATA_W  raw data-memory read word
- mem_rdy  in  1  mem_read_data valid this cycle
- rf_wen  out  1  register-file write strobe
- rf_waddr  out  5  register-file write address
- rf_wdata  out  DATA_W  register-file write data
- fwd_valid  out  1  forwarding bus valid (equals rf_wen)
- fwd_w  out  5  forwarding destination
- fwd_data  out  DATA_W  forwarding data
- align_err  out  1  one-cycle pulse: misaligned load
- bus_err  out  1  sticky: load timeout; cleared only by reset
- retire_cnt  out  CNT_W  retired instructions (optional feature)

Behaviour:
- Reset (asynchronous) values: state IDLE; rf_wen, fwd_valid, align_err and bus_err are 0; rf_waddr, rf_wdata, fwd_w and fwd_data are 0; retire_cnt is 0. Reset mid-WAIT abandons the load with no write.
- in_ready = (state == IDLE).
- Load = data_mem_en_in & !data_mem_wen_in. Store = data_mem_en_in & data_mem_wen_in.
- States are IDLE and WAIT.
- IDLE, in_valid & !load: the next cycle asserts rf_wen for one cycle with rf_wdata = alu_result_in, but only if reg_wen_in & !store & w_in != 0. Otherwise rf_wen = 0 and the instruction still retires.
- IDLE, in_valid & load & mem_rdy: extract, then write next cycle (latency 1).
- IDLE, in_valid & load & !mem_rdy: capture w_in, addr[1:0], size and signed into hold registers; go to WAIT; clear the wait counter.
- WAIT, mem_rdy: extract using the held controls; write next cycle; go to IDLE.
- WAIT, counter reaches WAIT_MAX: set bus_err; no write; return to IDLE; the instruction is not retired.
- Extraction is big-endian:
  - Byte: addr 00 gives bits [31:24], 01 gives [23:16], 10 gives [15:8], 11 gives [7:0].
  - Half: addr[1]=0 gives [31:16], addr[1]=1 gives [15:0].
  - Zero- or sign-extended to DATA_W per load_signed_in.
- Half load with addr[0]=1, or word load with addr[1:0] != 0: pulse align_err for one cycle; no write; the instruction retires.
- Writes to r0 are suppressed (rf_wen = 0).
- The forwarding outputs mirror the write port in the same cycle.
- in_valid low in IDLE: rf_wen = 0 next cycle.

Optional Feature:
- Macro WB_RETIRE_CNT_EN.
- Defined: retire_cnt increments by 1 in the cycle after each retired instruction (ALU op, store, completed load, aligned-error load); it wraps at 2^CNT_W - 1 back to 0.
- Undefined: the counter register is omitted and retire_cnt is tied to 0.

Decomposition:
- Shared package mips_pkg: load size encodings (LS_WORD, LS_HALF, LS_BYTE), REG_ZERO = 5'd0, WB state encoding.
- Sub-module load_align: combinational extraction plus alignment check. Inputs: word, addr[1:0], size, signed. Outputs: data, misaligned.

Test Plan:
- ALU op, w_in=5, alu_result_in=0x1234_5678, reg_wen_in=1 -> next cycle rf_wen=1, rf_waddr=5, rf_wdata=0x1234_5678, fwd_valid=1.
- Byte load, signed, addr=0x...01, mem_read_data=0x11_80_22_33, mem_rdy=1 -> rf_wdata=0xFFFF_FF80; the same with unsigned -> 0x0000_0080.
- Word load, mem_rdy low for 3 cycles then high with data 0xDEAD_BEEF -> in_ready=0 for 3 cycles, then rf_wen=1 with 0xDEAD_BEEF one cycle after mem_rdy.
- mem_rdy never asserted -> bus_err=1 after WAIT_MAX (15) cycles, no rf_wen, in_ready returns to 1.
- Half load with addr[0]=1 -> align_err pulse, rf_wen=0; store with reg_wen_in=1 -> rf_wen=0; ALU op to w_in=0 -> rf_wen=0.
- Reset asserted during WAIT -> all outputs 0 immediately; the late mem_rdy is ignored. With WB_RETIRE_CNT_EN defined, 10 retired ops -> retire_cnt=10.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: load-size encodings, register constants and
// the write-back state encoding.
package mips_pkg;

  localparam logic [1:0] LS_WORD  = 2'b00;
  localparam logic [1:0] LS_HALF  = 2'b01;
  localparam logic [1:0] LS_BYTE  = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_WAIT = 1'b1
  } wb_state_t;

  // Load controls that must survive while a slow load is outstanding.
  typedef struct packed {
    logic [4:0] w;
    logic [1:0] addr;
    logic [1:0] size;
    logic       sgn;
  } ld_hold_t;

endpackage

// File: rtl/wb_stage_if.sv
// MEM-to-WB handoff: registered MEM outputs, data-memory read return and the
// WB ready back-pressure.
interface wb_stage_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] alu_result_in;
  logic [4:0]        w_in;
  logic              data_mem_en_in;
  logic              data_mem_wen_in;
  logic              reg_wen_in;
  logic [1:0]        load_size_in;
  logic              load_signed_in;
  logic [DATA_W-1:0] mem_read_data;
  logic              mem_rdy;

  modport master (
    output in_valid, alu_result_in, w_in, data_mem_en_in, data_mem_wen_in,
           reg_wen_in, load_size_in, load_signed_in, mem_read_data, mem_rdy,
    input  in_ready
  );

  modport slave (
    input  in_valid, alu_result_in, w_in, data_mem_en_in, data_mem_wen_in,
           reg_wen_in, load_size_in, load_signed_in, mem_read_data, mem_rdy,
    output in_ready
  );
endinterface

// File: rtl/wb_stage_load_align.sv
// Big-endian load extraction (byte/half/word, zero or sign extended) and the
// alignment check; purely combinational.
module load_align
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        addr,
  input  logic [1:0]        size,
  input  logic              load_signed,
  output logic [DATA_W-1:0] data,
  output logic              misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel   = word[7:0];
    half_sel   = addr[1] ? word[15:0] : word[DATA_W-1 -: 16];
    data       = word;
    misaligned = 1'b0;

    case (addr)
      2'b00:   byte_sel = word[DATA_W-1 -: 8];
      2'b01:   byte_sel = word[DATA_W-9 -: 8];
      2'b10:   byte_sel = word[15:8];
      default: byte_sel = word[7:0];
    endcase

    // Reserved size 2'b11 falls through to the word case.
    case (size)
      LS_HALF: begin
        data       = {{(DATA_W-16){load_signed & half_sel[15]}}, half_sel};
        misaligned = addr[0];
      end
      LS_BYTE: data = {{(DATA_W-8){load_signed & byte_sel[7]}}, byte_sel};
      default: misaligned = (addr != 2'b00);
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MIPS write-back stage: load extraction, multi-cycle load wait with timeout,
// register-file write port and forwarding bus. Optional WB_RETIRE_CNT_EN adds a retire counter.
module wb_stage
  import mips_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  wb_stage_if.slave         mem,
  output logic              rf_wen,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              fwd_valid,
  output logic [4:0]        fwd_w,
  output logic [DATA_W-1:0] fwd_data,
  output logic              align_err,
  output logic              bus_err,
  output logic [CNT_W-1:0]  retire_cnt
);

  localparam int WCNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  wb_state_t         state, state_nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;
  ld_hold_t          hold, hold_nxt, ctl;
  logic              load, store, mis;
  logic [DATA_W-1:0] ext;
  logic              wen_nxt, aerr_nxt, berr_nxt;
  logic [4:0]        waddr_nxt;
  logic [DATA_W-1:0] wdata_nxt;

  assign load         = mem.data_mem_en_in & ~mem.data_mem_wen_in;
  assign store        = mem.data_mem_en_in &  mem.data_mem_wen_in;
  assign mem.in_ready = (state == WB_IDLE);

  // In IDLE the live MEM controls drive extraction; in WAIT the held copy does.
  always_comb begin
    ctl = hold;
    if (state == WB_IDLE) begin
      ctl = '{w: mem.w_in, addr: mem.alu_result_in[1:0],
              size: mem.load_size_in, sgn: mem.load_signed_in};
    end
  end

  load_align #(.DATA_W(DATA_W)) u_load_align (
    .word        (mem.mem_read_data),
    .addr        (ctl.addr),
    .size        (ctl.size),
    .load_signed (ctl.sgn),
    .data        (ext),
    .misaligned  (mis)
  );

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    hold_nxt  = hold;
    wen_nxt   = 1'b0;
    waddr_nxt = rf_waddr;
    wdata_nxt = rf_wdata;
    aerr_nxt  = 1'b0;
    berr_nxt  = bus_err;

    case (state)
      WB_IDLE: begin
        if (mem.in_valid) begin
          if (!load) begin
            if (mem.reg_wen_in && !store && mem.w_in != REG_ZERO) begin
              wen_nxt   = 1'b1;
              waddr_nxt = mem.w_in;
              wdata_nxt = mem.alu_result_in;
            end
          end else if (mis) begin
            aerr_nxt = 1'b1;
          end else if (mem.mem_rdy) begin
            if (mem.w_in != REG_ZERO) begin
              wen_nxt   = 1'b1;
              waddr_nxt = mem.w_in;
              wdata_nxt = ext;
            end
          end else begin
            hold_nxt  = ctl;
            wcnt_nxt  = '0;
            state_nxt = WB_WAIT;
          end
        end
      end
      WB_WAIT: begin
        if (mem.mem_rdy) begin
          if (hold.w != REG_ZERO) begin
            wen_nxt   = 1'b1;
            waddr_nxt = hold.w;
            wdata_nxt = ext;
          end
          state_nxt = WB_IDLE;
        end else if (wcnt == WCNT_W'(WAIT_MAX - 1)) begin
          berr_nxt  = 1'b1;
          state_nxt = WB_IDLE;
        end else begin
          wcnt_nxt = wcnt + 1'b1;
        end
      end
      default: state_nxt = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= WB_IDLE;
      wcnt      <= '0;
      hold      <= '0;
      rf_wen    <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      align_err <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      wcnt      <= wcnt_nxt;
      hold      <= hold_nxt;
      rf_wen    <= wen_nxt;
      rf_waddr  <= waddr_nxt;
      rf_wdata  <= wdata_nxt;
      align_err <= aerr_nxt;
      bus_err   <= berr_nxt;
    end
  end

  assign fwd_valid = rf_wen;
  assign fwd_w     = rf_waddr;
  assign fwd_data  = rf_wdata;

`ifdef WB_RETIRE_CNT_EN
  // Timed-out loads never retire; misaligned loads do.
  logic retire;
  assign retire = ((state == WB_IDLE) && mem.in_valid && (!load || mis || mem.mem_rdy))
               || ((state == WB_WAIT) && mem.mem_rdy);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       retire_cnt <= '0;
    else if (retire) retire_cnt <= retire_cnt + 1'b1;
  end
`else
  assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: table of single-cycle ops plus hand sequences
// for slow loads, timeout, reset during WAIT and retire counting.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        rf_wen, fwd_valid, align_err, bus_err;
  logic [4:0]  rf_waddr, fwd_w;
  logic [31:0] rf_wdata, fwd_data, retire_cnt;

  int total = 0;
  int bad   = 0;
  int exp_ret = 0;

  wb_stage_if #(.DATA_W(32)) bus ();

  wb_stage #(.DATA_W(32), .WAIT_MAX(15), .CNT_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem        (bus),
    .rf_wen     (rf_wen),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .fwd_valid  (fwd_valid),
    .fwd_w      (fwd_w),
    .fwd_data   (fwd_data),
    .align_err  (align_err),
    .bus_err    (bus_err),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [31:0] alu;
    logic [4:0]  w;
    logic        en;
    logic        wen;
    logic        rwen;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] rdata;
    logic        exp_wen;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
    logic        exp_aerr;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt();
`ifdef WB_RETIRE_CNT_EN
    return 32'(exp_ret);
`else
    return 32'd0;
`endif
  endfunction

  task automatic drive(input vec_t v, input logic rdy);
    bus.in_valid        = v.vld;
    bus.alu_result_in   = v.alu;
    bus.w_in            = v.w;
    bus.data_mem_en_in  = v.en;
    bus.data_mem_wen_in = v.wen;
    bus.reg_wen_in      = v.rwen;
    bus.load_size_in    = v.size;
    bus.load_signed_in  = v.sgn;
    bus.mem_read_data   = v.rdata;
    bus.mem_rdy         = rdy;
  endtask

  task automatic alu_op(input logic [4:0] w, input logic [31:0] val);
    vec_t v;
    v = '{1'b1, val, w, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0};
    @(negedge clk);
    drive(v, 1'b0);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    exp_ret++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   waits;
    logic saw_wen, saw_berr;

    //        vld  alu            w      en wen rwen size  sgn rdata         ewen ewaddr  ewdata         aerr
    vecs[0]  = '{1, 32'h1234_5678, 5'd5,  0, 0, 1, 2'b00, 0, 32'h0,         1, 5'd5,  32'h1234_5678, 0};
    vecs[1]  = '{1, 32'h0000_1001, 5'd3,  1, 0, 1, 2'b10, 1, 32'h1180_2233, 1, 5'd3,  32'hFFFF_FF80, 0};
    vecs[2]  = '{1, 32'h0000_1001, 5'd3,  1, 0, 1, 2'b10, 0, 32'h1180_2233, 1, 5'd3,  32'h0000_0080, 0};
    vecs[3]  = '{1, 32'h0000_1003, 5'd4,  1, 0, 1, 2'b10, 1, 32'h1180_2233, 1, 5'd4,  32'h0000_0033, 0};
    vecs[4]  = '{1, 32'h0000_1000, 5'd4,  1, 0, 1, 2'b10, 1, 32'h9180_2233, 1, 5'd4,  32'hFFFF_FF91, 0};
    vecs[5]  = '{1, 32'h0000_1002, 5'd13, 1, 0, 1, 2'b10, 0, 32'h1180_2233, 1, 5'd13, 32'h0000_0022, 0};
    vecs[6]  = '{1, 32'h0000_2002, 5'd6,  1, 0, 1, 2'b01, 1, 32'h1234_8001, 1, 5'd6,  32'hFFFF_8001, 0};
    vecs[7]  = '{1, 32'h0000_2000, 5'd6,  1, 0, 1, 2'b01, 0, 32'h8001_1234, 1, 5'd6,  32'h0000_8001, 0};
    vecs[8]  = '{1, 32'h0000_2000, 5'd7,  1, 0, 1, 2'b01, 1, 32'h7FFF_0000, 1, 5'd7,  32'h0000_7FFF, 0};
    vecs[9]  = '{1, 32'h0000_2000, 5'd31, 1, 0, 1, 2'b00, 0, 32'hCAFE_F00D, 1, 5'd31, 32'hCAFE_F00D, 0};
    vecs[10] = '{1, 32'h0000_2001, 5'd8,  1, 0, 1, 2'b01, 0, 32'hAAAA_BBBB, 0, 5'd0,  32'h0,         1};
    vecs[11] = '{1, 32'h0000_2002, 5'd8,  1, 0, 1, 2'b00, 0, 32'hAAAA_BBBB, 0, 5'd0,  32'h0,         1};
    vecs[12] = '{1, 32'h0000_3000, 5'd8,  1, 1, 1, 2'b00, 0, 32'h0,         0, 5'd0,  32'h0,         0};
    vecs[13] = '{1, 32'h5555_5555, 5'd0,  0, 0, 1, 2'b00, 0, 32'h0,         0, 5'd0,  32'h0,         0};
    vecs[14] = '{1, 32'h5555_5555, 5'd7,  0, 0, 0, 2'b00, 0, 32'h0,         0, 5'd0,  32'h0,         0};
    vecs[15] = '{1, 32'h0000_4000, 5'd10, 1, 0, 1, 2'b11, 1, 32'h0102_0304, 1, 5'd10, 32'h0102_0304, 0};
    vecs[16] = '{1, 32'h0000_4000, 5'd0,  1, 0, 1, 2'b00, 0, 32'h0102_0304, 0, 5'd0,  32'h0,         0};
    vecs[17] = '{0, 32'h6666_6666, 5'd5,  0, 0, 1, 2'b00, 0, 32'h0,         0, 5'd0,  32'h0,         0};
    vecs[18] = '{1, 32'hFFFF_FFFF, 5'd12, 0, 0, 1, 2'b00, 0, 32'h0,         1, 5'd12, 32'hFFFF_FFFF, 0};

    reset = 1'b1;
    v = '{1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0};
    drive(v, 1'b0);
    #12;
    chk("reset_rf_wen", 32'(rf_wen), 32'd0);
    chk("reset_rf_waddr", 32'(rf_waddr), 32'd0);
    chk("reset_rf_wdata", rf_wdata, 32'd0);
    chk("reset_fwd_valid", 32'(fwd_valid), 32'd0);
    chk("reset_fwd_w", 32'(fwd_w), 32'd0);
    chk("reset_fwd_data", fwd_data, 32'd0);
    chk("reset_align_err", 32'(align_err), 32'd0);
    chk("reset_bus_err", 32'(bus_err), 32'd0);
    chk("reset_retire_cnt", retire_cnt, 32'd0);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(vecs[i], 1'b1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      if (vecs[i].vld) exp_ret++;
      chk($sformatf("vec%0d_rf_wen", i), 32'(rf_wen), 32'(vecs[i].exp_wen));
      chk($sformatf("vec%0d_fwd_valid", i), 32'(fwd_valid), 32'(vecs[i].exp_wen));
      chk($sformatf("vec%0d_align_err", i), 32'(align_err), 32'(vecs[i].exp_aerr));
      chk($sformatf("vec%0d_retire_cnt", i), retire_cnt, exp_cnt());
      if (vecs[i].exp_wen) begin
        chk($sformatf("vec%0d_rf_waddr", i), 32'(rf_waddr), 32'(vecs[i].exp_waddr));
        chk($sformatf("vec%0d_rf_wdata", i), rf_wdata, vecs[i].exp_wdata);
        chk($sformatf("vec%0d_fwd_w", i), 32'(fwd_w), 32'(vecs[i].exp_waddr));
        chk($sformatf("vec%0d_fwd_data", i), fwd_data, vecs[i].exp_wdata);
      end
    end

    // Slow word load: mem_rdy low at accept and for two WAIT cycles.
    @(negedge clk);
    v = '{1'b1, 32'h0000_0100, 5'd9, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0};
    drive(v, 1'b0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("slow_accept_rf_wen", 32'(rf_wen), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.mem_rdy       = (i == 2);
      bus.mem_read_data = 32'hDEAD_BEEF;
      chk($sformatf("slow_in_ready_c%0d", i), 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("slow_rf_wen_c%0d", i), 32'(rf_wen), 32'(i == 2));
    end
    bus.mem_rdy = 1'b0;
    exp_ret++;
    chk("slow_rf_waddr", 32'(rf_waddr), 32'd9);
    chk("slow_rf_wdata", rf_wdata, 32'hDEAD_BEEF);
    chk("slow_fwd_data", fwd_data, 32'hDEAD_BEEF);
    chk("slow_in_ready_after", 32'(bus.in_ready), 32'd1);
    chk("slow_retire_cnt", retire_cnt, exp_cnt());

    // mem_rdy never arrives: expect 15 WAIT cycles then sticky bus_err.
    @(negedge clk);
    v = '{1'b1, 32'h0000_0200, 5'd4, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0};
    drive(v, 1'b0);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    waits = 0;
    saw_wen = 1'b0;
    saw_berr = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.in_ready) break;
      waits++;
      if (rf_wen) saw_wen = 1'b1;
      if (bus_err) saw_berr = 1'b1;
    end
    chk("timeout_wait_cycles", 32'(waits), 32'd15);
    chk("timeout_bus_err", 32'(bus_err), 32'd1);
    chk("timeout_early_bus_err", 32'(saw_berr), 32'd0);
    chk("timeout_rf_wen", 32'(saw_wen | rf_wen), 32'd0);
    chk("timeout_retire_cnt", retire_cnt, exp_cnt());
    alu_op(5'd2, 32'h0000_00AA);
    chk("sticky_bus_err", 32'(bus_err), 32'd1);
    chk("sticky_alu_wdata", rf_wdata, 32'h0000_00AA);
    chk("sticky_retire_cnt", retire_cnt, exp_cnt());

    // Reset while WAITing abandons the load; the late mem_rdy must not write.
    @(negedge clk);
    v = '{1'b1, 32'h0000_0300, 5'd11, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0};
    drive(v, 1'b0);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk("rstwait_in_ready_before", 32'(bus.in_ready), 32'd0);
    reset = 1'b1;
    exp_ret = 0;
    #1;
    chk("rstwait_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rstwait_bus_err", 32'(bus_err), 32'd0);
    chk("rstwait_rf_wen", 32'(rf_wen), 32'd0);
    chk("rstwait_rf_waddr", 32'(rf_waddr), 32'd0);
    chk("rstwait_rf_wdata", rf_wdata, 32'd0);
    chk("rstwait_fwd_data", fwd_data, 32'd0);
    chk("rstwait_retire_cnt", retire_cnt, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.mem_rdy = 1'b1;
    bus.mem_read_data = 32'h5555_AAAA;
    @(posedge clk);
    #1;
    chk("rstwait_late_rdy_rf_wen", 32'(rf_wen), 32'd0);
    chk("rstwait_late_rdy_in_ready", 32'(bus.in_ready), 32'd1);
    bus.mem_rdy = 1'b0;

    for (int i = 0; i < 10; i++) alu_op(5'(i + 1), 32'(i * 3));
    chk("ten_ops_retire_cnt", retire_cnt, exp_cnt());
    chk("ten_ops_last_waddr", 32'(rf_waddr), 32'd10);
    chk("ten_ops_last_wdata", rf_wdata, 32'd27);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
